// File: rtl/mst_imp_rd_dma.sv
// AXI4-lite read master: fetches an HSIZE x VSIZE word window of a pitched frame into a pixel stream.
// Optional statistics counters are enabled by defining IMP_RD_STAT_EN.
module mst_imp_rd_dma #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int DIM_W    = 8,
   parameter int MAX_OUTS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_axi_arvalid,
   input  logic              mem_axi_arready,
   output logic [ADDR_W-1:0] mem_axi_araddr,
   output logic [2:0]        mem_axi_arprot,
   input  logic              mem_axi_rvalid,
   output logic              mem_axi_rready,
   input  logic [DATA_W-1:0] mem_axi_rdata,
   input  logic [1:0]        mem_axi_rresp,
   input  logic              IMP_ST,
   input  logic [DIM_W-1:0]  IMP_HSIZE,
   input  logic [DIM_W-1:0]  IMP_VSIZE,
   input  logic [DIM_W-1:0]  IMP_COOR_MINX,
   input  logic [DIM_W-1:0]  IMP_COOR_MINY,
   input  logic [ADDR_W-1:0] IMP_SRC_BADDR,
   input  logic [ADDR_W-1:0] IMP_ADR_PITCH,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_eol,
   output logic              pix_eof,
   output logic              imp_busy,
   output logic              imp_done,
   output logic              imp_err,
   output logic [31:0]       stat_beats,
   output logic [31:0]       stat_stall
);
   localparam int PTR_W = $clog2(MAX_OUTS);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(DATA_W / 8);
   localparam logic [CNT_W:0]    MAX_C   = (CNT_W + 1)'(MAX_OUTS);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              st_q, st_prev_q;
   logic [DIM_W-1:0]  hsize_q, hsize_d, vsize_q, vsize_d;
   logic [DIM_W-1:0]  x_q, x_d, y_q, y_d, rx_x_q, rx_x_d, rx_y_q, rx_y_d;
   logic [ADDR_W-1:0] pitch_q, pitch_d, row_base_q, row_base_d, araddr_q, araddr_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d, count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_W+1:0] mem_q [MAX_OUTS];
   logic [DATA_W+1:0] mem_d [MAX_OUTS];
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic              trigger, credit, ar_hs, r_acc, pop, last_x, last_y, rx_eol, rx_eof;
   logic [ADDR_W-1:0] start_addr;

   // Valid/ready: a transfer happens on any edge where valid and ready are both high;
   // a raised valid is never withdrawn before its transfer.
   assign trigger    = (state_q == ST_IDLE) && st_q && !st_prev_q;
   assign credit     = ({1'b0, inflight_q} + {1'b0, count_q}) < MAX_C;
   assign mem_axi_arvalid = (state_q == ST_ISSUE) && credit;
   assign ar_hs      = mem_axi_arvalid && mem_axi_arready;
   // Beats with nothing outstanding are leftovers from before a reset and are dropped.
   assign r_acc      = mem_axi_rvalid && (inflight_q != '0);
   assign pop        = pix_valid && pix_ready;
   assign last_x     = (x_q == hsize_q - 1'b1);
   assign last_y     = (y_q == vsize_q - 1'b1);
   assign rx_eol     = (rx_x_q == hsize_q - 1'b1);
   assign rx_eof     = rx_eol && (rx_y_q == vsize_q - 1'b1);
   assign start_addr = IMP_SRC_BADDR + ADDR_W'(IMP_COOR_MINY) * IMP_ADR_PITCH
                       + ADDR_W'(IMP_COOR_MINX) * BYTES_A;

   assign mem_axi_araddr = araddr_q;
   assign mem_axi_arprot = 3'b000;
   assign mem_axi_rready = 1'b1;
   assign pix_valid      = (count_q != '0);
   assign {pix_data, pix_eol, pix_eof} = pix_valid ? mem_q[rd_ptr_q] : '0;
   assign imp_busy       = busy_q;
   assign imp_done       = done_q;
   assign imp_err        = err_q;

   always_comb begin
      state_d    = state_q;
      hsize_d    = hsize_q;
      vsize_d    = vsize_q;
      pitch_d    = pitch_q;
      row_base_d = row_base_q;
      araddr_d   = araddr_q;
      x_d        = x_q;
      y_d        = y_q;
      rx_x_d     = rx_x_q;
      rx_y_d     = rx_y_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      mem_d      = mem_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      if (trigger) begin
         hsize_d    = IMP_HSIZE;
         vsize_d    = IMP_VSIZE;
         pitch_d    = IMP_ADR_PITCH;
         row_base_d = start_addr;
         araddr_d   = start_addr;
         x_d        = '0;
         y_d        = '0;
         rx_x_d     = '0;
         rx_y_d     = '0;
         err_d      = 1'b0;
         if (IMP_HSIZE == '0 || IMP_VSIZE == '0) begin
            done_d = 1'b1;
         end else begin
            busy_d  = 1'b1;
            state_d = ST_ISSUE;
         end
      end
      // Row base steps by the pitch so no multiplier sits in the per-beat address path.
      if (ar_hs) begin
         if (last_x) begin
            x_d        = '0;
            y_d        = y_q + 1'b1;
            row_base_d = row_base_q + pitch_q;
            araddr_d   = row_base_q + pitch_q;
            if (last_y) state_d = ST_DRAIN;
         end else begin
            x_d      = x_q + 1'b1;
            araddr_d = araddr_q + BYTES_A;
         end
      end
      if (r_acc) begin
         mem_d[wr_ptr_q] = {mem_axi_rdata, rx_eol, rx_eof};
         wr_ptr_d        = wr_ptr_q + 1'b1;
         if (mem_axi_rresp != 2'b00) err_d = 1'b1;
         if (rx_eol) begin
            rx_x_d = '0;
            rx_y_d = rx_y_q + 1'b1;
         end else begin
            rx_x_d = rx_x_q + 1'b1;
         end
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({r_acc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      case ({ar_hs, r_acc})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
      if ((state_q == ST_DRAIN) && pop && pix_eof && (inflight_q == '0)) begin
         done_d  = 1'b1;
         busy_d  = 1'b0;
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         st_q       <= 1'b0;
         st_prev_q  <= 1'b0;
         hsize_q    <= '0;
         vsize_q    <= '0;
         pitch_q    <= '0;
         row_base_q <= '0;
         araddr_q   <= '0;
         x_q        <= '0;
         y_q        <= '0;
         rx_x_q     <= '0;
         rx_y_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         for (int i = 0; i < MAX_OUTS; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         st_q       <= IMP_ST;
         st_prev_q  <= st_q;
         hsize_q    <= hsize_d;
         vsize_q    <= vsize_d;
         pitch_q    <= pitch_d;
         row_base_q <= row_base_d;
         araddr_q   <= araddr_d;
         x_q        <= x_d;
         y_q        <= y_d;
         rx_x_q     <= rx_x_d;
         rx_y_q     <= rx_y_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         mem_q      <= mem_d;
      end
   end

`ifdef IMP_RD_STAT_EN
   logic [31:0] beats_q, beats_d, stall_q, stall_d;

   always_comb begin
      beats_d = beats_q;
      stall_d = stall_q;
      if (trigger) begin
         beats_d = '0;
         stall_d = '0;
      end else begin
         if (r_acc && beats_q != 32'hFFFF_FFFF) beats_d = beats_q + 1'b1;
         if (mem_axi_arvalid && !mem_axi_arready && stall_q != 32'hFFFF_FFFF)
            stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beats_q <= '0;
         stall_q <= '0;
      end else begin
         beats_q <= beats_d;
         stall_q <= stall_d;
      end
   end

   assign stat_beats = beats_q;
   assign stat_stall = stall_q;
`else
   assign stat_beats = '0;
   assign stat_stall = '0;
`endif
endmodule

// File: tb/tb_mst_imp_rd_dma.sv
// Directed bench for mst_imp_rd_dma: behavioural AXI read slave, pixel sink and scoreboard.
module tb_mst_imp_rd_dma;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] araddr, rdata, pix_data, stat_beats, stat_stall;
   logic [2:0]  arprot;
   logic [1:0]  rresp;
   logic        imp_st, pix_valid, pix_ready, pix_eol, pix_eof, imp_busy, imp_done, imp_err;
   logic [7:0]  imp_hsize, imp_vsize, imp_minx, imp_miny;
   logic [31:0] imp_baddr, imp_pitch;

   always #5 clk = ~clk;

   mst_imp_rd_dma dut (
      .clk(clk), .rst_n(rst_n),
      .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
      .mem_axi_arprot(arprot), .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
      .mem_axi_rdata(rdata), .mem_axi_rresp(rresp),
      .IMP_ST(imp_st), .IMP_HSIZE(imp_hsize), .IMP_VSIZE(imp_vsize),
      .IMP_COOR_MINX(imp_minx), .IMP_COOR_MINY(imp_miny),
      .IMP_SRC_BADDR(imp_baddr), .IMP_ADR_PITCH(imp_pitch),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_eol(pix_eol), .pix_eof(pix_eof), .imp_busy(imp_busy), .imp_done(imp_done),
      .imp_err(imp_err), .stat_beats(stat_beats), .stat_stall(stat_stall)
   );

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave and sink state
   logic [31:0] rq_addr[$];
   int          rq_due[$];
   logic [31:0] exp_addr_q[$];
   logic [33:0] exp_q[$];
   int          cyc = 0, lat = 1, beat_idx = 0, err_beat = -1;
   int          ar_cnt = 0, stall_cnt = 0, done_cnt = 0;
   bit          ar_toggle = 0, prev_stall = 0;
   logic [31:0] prev_araddr = '0;

   always @(posedge clk) begin
      cyc++;
      if (rst_n) begin
         if (prev_stall) begin
            check("arvalid_held", arvalid, 1);
            check("araddr_stable", araddr, prev_araddr);
         end
         if (arvalid && !arready) stall_cnt++;
         prev_stall  = arvalid && !arready;
         prev_araddr = araddr;
         if (arvalid && arready) begin
            ar_cnt++;
            if (exp_addr_q.size() == 0) check("ar_extra", 1, 0);
            else check("araddr", araddr, exp_addr_q.pop_front());
            rq_addr.push_back(araddr);
            rq_due.push_back(cyc + lat - 1);
            check("inflight_le_max", rq_addr.size() <= 4, 1);
         end
         if (rvalid && rready && rq_addr.size() > 0) begin
            void'(rq_addr.pop_front());
            void'(rq_due.pop_front());
            beat_idx++;
         end
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) check("pix_extra", 1, 0);
            else check("pix_word", {pix_data, pix_eol, pix_eof}, exp_q.pop_front());
         end
         if (imp_done) begin
            done_cnt++;
            check("busy_low_at_done", imp_busy, 0);
         end
      end else begin
         prev_stall = 0;
      end
      #1;
      if (!rst_n) begin
         rq_addr.delete();
         rq_due.delete();
         rvalid = 1'b0;
         rresp  = 2'b00;
      end else begin
         arready = ar_toggle ? ((cyc % 2) == 0) : 1'b1;
         if (rq_addr.size() > 0 && cyc >= rq_due[0]) begin
            rvalid = 1'b1;
            rdata  = ~rq_addr[0];
            rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
         end else begin
            rvalid = 1'b0;
            rresp  = 2'b00;
         end
      end
   end

   task automatic add_word(input logic [31:0] addr, input logic eol, input logic eof);
      exp_addr_q.push_back(addr);
      exp_q.push_back({~addr, eol, eof});
   endtask

   // Returns #1 after the trigger edge; config inputs are scrambled afterwards.
   task automatic start_task(input logic [31:0] baddr, input logic [31:0] pitch,
                             input logic [7:0] minx, input logic [7:0] miny,
                             input logic [7:0] h, input logic [7:0] v);
      @(posedge clk);
      #1;
      imp_baddr = baddr; imp_pitch = pitch; imp_minx = minx; imp_miny = miny;
      imp_hsize = h; imp_vsize = v; beat_idx = 0;
      imp_st = 1'b1;
      @(posedge clk);
      #1;
      imp_st = 1'b0;
      check("busy_before_trigger", imp_busy, 0);
      @(posedge clk);
      #1;
      imp_baddr = 32'hDEAD_BEEF; imp_pitch = 32'h1234; imp_minx = 8'h55; imp_miny = 8'h66;
      imp_hsize = 8'hFF; imp_vsize = 8'hFF;
   endtask

   task automatic wait_done(input string tag);
      int d0 = done_cnt;
      int k = 0;
      while (done_cnt == d0 && k < 3000) begin
         @(posedge clk);
         k++;
      end
      #1;
      check({tag, "_done_count"}, done_cnt - d0, 1);
      check({tag, "_done_width"}, imp_done, 0);
      check({tag, "_busy_after"}, imp_busy, 0);
      check({tag, "_words_left"}, exp_q.size(), 0);
      check({tag, "_ars_left"}, exp_addr_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_arvalid"}, arvalid, 0);
      check({tag, "_araddr"}, araddr, 0);
      check({tag, "_arprot"}, arprot, 0);
      check({tag, "_rready"}, rready, 1);
      check({tag, "_pix_valid"}, pix_valid, 0);
      check({tag, "_pix_word"}, {pix_data, pix_eol, pix_eof}, 0);
      check({tag, "_busy"}, imp_busy, 0);
      check({tag, "_done"}, imp_done, 0);
      check({tag, "_err"}, imp_err, 0);
      check({tag, "_stats"}, {stat_beats, stat_stall}, 0);
   endtask

   logic [31:0] basic_addr [8];

   initial begin
      rst_n = 1'b0; imp_st = 1'b0; pix_ready = 1'b1; arready = 1'b1; rvalid = 1'b0;
      rdata = '0; rresp = 2'b00;
      imp_hsize = '0; imp_vsize = '0; imp_minx = '0; imp_miny = '0; imp_baddr = '0; imp_pitch = '0;
      #1;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;

      // Basic 4x2 window
      basic_addr = '{32'h1000, 32'h1004, 32'h1008, 32'h100C,
                     32'h1100, 32'h1104, 32'h1108, 32'h110C};
      for (int i = 0; i < 8; i++) add_word(basic_addr[i], (i % 4) == 3, i == 7);
      start_task(32'h1000, 32'h100, 8'd0, 8'd0, 8'd4, 8'd2);
      check("basic_busy_n2", imp_busy, 1);
      check("basic_arvalid_n2", arvalid, 1);
      check("basic_first_addr", araddr, 32'h1000);
      wait_done("basic");
      check("basic_err", imp_err, 0);
`ifdef IMP_RD_STAT_EN
      check("basic_stat_beats", stat_beats, 8);
      check("basic_stat_stall", stat_stall, 0);
`else
      check("basic_stat_tied", {stat_beats, stat_stall}, 0);
`endif

      // Offset single word: 0 + 3*0x40 + 2*4 = 0xC8
      add_word(32'hC8, 1'b1, 1'b1);
      start_task(32'h0, 32'h40, 8'd2, 8'd3, 8'd1, 8'd1);
      check("offset_addr", araddr, 32'hC8);
      wait_done("offset");

      // Backpressure: 8x2 at 0x2000, pitch 0x80
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 8; x++)
            add_word(32'h2000 + y * 32'h80 + x * 4, x == 7, (x == 7) && (y == 1));
      pix_ready = 1'b0;
      ar_cnt = 0;
      start_task(32'h2000, 32'h80, 8'd0, 8'd0, 8'd8, 8'd2);
      repeat (20) @(posedge clk);
      #1;
      check("bp_ar_count", ar_cnt, 4);
      check("bp_arvalid_low", arvalid, 0);
      check("bp_pix_valid", pix_valid, 1);
      pix_ready = 1'b1;
      wait_done("bp");
      check("bp_total_ars", ar_cnt, 16);

      // Slow slave: 4x4 at 0x8000_0000 + (1+y)*0x400 + 4 + 4x
      ar_toggle = 1; lat = 7; stall_cnt = 0;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++)
            add_word(32'h8000_0404 + y * 32'h400 + x * 4, x == 3, (x == 3) && (y == 3));
      start_task(32'h8000_0000, 32'h400, 8'd1, 8'd1, 8'd4, 8'd4);
      wait_done("slow");
      check("slow_stalls_seen", stall_cnt > 0, 1);
`ifdef IMP_RD_STAT_EN
      check("slow_stat_stall", stat_stall, stall_cnt);
      check("slow_stat_beats", stat_beats, 16);
`else
      check("slow_stat_tied", {stat_beats, stat_stall}, 0);
`endif
      ar_toggle = 0; lat = 1;

      // Address wrap past 2^32
      add_word(32'hFFFF_FF00, 0, 0); add_word(32'hFFFF_FF04, 1, 0);
      add_word(32'h0000_0000, 0, 0); add_word(32'h0000_0004, 1, 1);
      start_task(32'hFFFF_FF00, 32'h100, 8'd0, 8'd0, 8'd2, 8'd2);
      wait_done("wrap");

      // Error response on the third beat
      for (int x = 0; x < 4; x++) add_word(32'h3000 + x * 4, x == 3, x == 3);
      err_beat = 2;
      start_task(32'h3000, 32'h10, 8'd0, 8'd0, 8'd4, 8'd1);
      wait_done("err");
      check("err_sticky", imp_err, 1);
      err_beat = -1;

      // Zero-size task: done right after trigger, no AR, error cleared
      ar_cnt = 0;
      start_task(32'h3000, 32'h10, 8'd0, 8'd0, 8'd0, 8'd3);
      check("zero_done", imp_done, 1);
      check("zero_err_cleared", imp_err, 0);
      check("zero_busy", imp_busy, 0);
      check("zero_arvalid", arvalid, 0);
      @(posedge clk);
      #1;
      check("zero_done_width", imp_done, 0);
      check("zero_no_ar", ar_cnt, 0);

      // Reset mid-task with a partly full FIFO
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 8; x++)
            add_word(32'h4000 + y * 32'h100 + x * 4, x == 7, (x == 7) && (y == 3));
      pix_ready = 1'b0;
      start_task(32'h4000, 32'h100, 8'd0, 8'd0, 8'd8, 8'd4);
      repeat (3) @(posedge clk);
      #1;
      check("mid_pix_valid", pix_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      exp_addr_q.delete();
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      pix_ready = 1'b1;
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 3; x++)
            add_word(32'h5000 + y * 32'h20 + x * 4, x == 2, (x == 2) && (y == 1));
      start_task(32'h5000, 32'h20, 8'd0, 8'd0, 8'd3, 8'd2);
      check("post_rst_first_addr", araddr, 32'h5000);
      wait_done("post_rst");
      check("post_rst_err", imp_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
